// File: rtl/uart_bus_responder.sv
// Memory-mapped 8N1 UART (TXD/RXD/CON) on the CPU load/store peripheral bus,
// with a level interrupt and OR-mergeable read data.
`timescale 1ns/1ps
module uart_bus_responder #(
    parameter int unsigned BAUD_DIV = 5208,
    parameter logic [31:0] BASE     = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irqout
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;
    logic unused_wdata_bits;

    assign sel_txd = (addr == BASE);
    assign sel_rxd = (addr == BASE + 32'd4);
    assign sel_con = (addr == BASE + 32'd8);
    assign wr_txd  = wr & sel_txd;
    assign wr_con  = wr & sel_con;
    assign rd_rxd  = rd & sel_rxd;
    assign rd_con  = rd & sel_con;
    assign unused_wdata_bits = ^wdata[31:8];

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_irq_en_q, tx_irq_en_d;
    logic             rx_irq_en_q, rx_irq_en_d;
    logic             tx_busy, tx_bit_end, tx_finish;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_armed_q, rx_armed_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_overrun_q, rx_overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_meta_q, rx_s_q;
    logic             rx_bit_end, rx_store, frame_set;

    assign tx_busy    = (tx_state_q != TX_IDLE);
    assign tx_bit_end = (tx_cnt_q == BIT_LAST);
    assign rx_bit_end = (rx_cnt_q == BIT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_byte_d  = tx_byte_q;
        tx_line_d  = tx_line_q;
        tx_finish  = 1'b0;
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end
        case (tx_state_q)
            TX_IDLE: begin
                // A write landing on the edge where busy drops sees the old state and is dropped.
                if (wr_txd) begin
                    tx_byte_d  = wdata[7:0];
                    tx_state_d = TX_START;
                    tx_line_d  = 1'b0;
                    tx_cnt_d   = '0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_idx_d   = 3'd0;
                    tx_line_d  = tx_byte_q[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_idx_d  = tx_idx_q + 3'd1;
                        tx_line_d = tx_byte_q[tx_idx_q + 3'd1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_IDLE;
                    tx_finish  = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_armed_d = rx_armed_q;
        rx_store   = 1'b0;
        frame_set  = 1'b0;
        if (rx_state_q != RX_IDLE) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
        end
        case (rx_state_q)
            RX_IDLE: begin
                // Arming requires a high line first, so a low line after reset or a bad frame is ignored.
                if (rx_armed_q && !rx_s_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                    rx_armed_d = 1'b0;
                end else if (rx_s_q) begin
                    rx_armed_d = 1'b1;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = 3'd0;
                    rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_s_q) begin
                        rx_store  = 1'b1;
                        rx_byte_d = rx_shift_q;
                    end else begin
                        frame_set = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Sticky flags: a set on the same edge as the clearing read wins.
    always_comb begin
        tx_done_d    = tx_finish | (tx_done_q & ~rd_con);
        rx_valid_d   = rx_store | (rx_valid_q & ~rd_rxd);
        rx_overrun_d = (rx_store & rx_valid_q & ~rd_rxd) | (rx_overrun_q & ~rd_con);
        frame_err_d  = frame_set | (frame_err_q & ~rd_con);
        tx_irq_en_d  = wr_con ? wdata[0] : tx_irq_en_q;
        rx_irq_en_d  = wr_con ? wdata[1] : rx_irq_en_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_idx_q     <= '0;
            tx_byte_q    <= '0;
            tx_line_q    <= 1'b1;
            tx_done_q    <= 1'b0;
            tx_irq_en_q  <= 1'b0;
            rx_irq_en_q  <= 1'b0;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_idx_q     <= '0;
            rx_shift_q   <= '0;
            rx_byte_q    <= '0;
            rx_armed_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_meta_q    <= 1'b0;
            rx_s_q       <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_idx_q     <= tx_idx_d;
            tx_byte_q    <= tx_byte_d;
            tx_line_q    <= tx_line_d;
            tx_done_q    <= tx_done_d;
            tx_irq_en_q  <= tx_irq_en_d;
            rx_irq_en_q  <= rx_irq_en_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_idx_q     <= rx_idx_d;
            rx_shift_q   <= rx_shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_armed_q   <= rx_armed_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            frame_err_q  <= frame_err_d;
            rx_meta_q    <= uart_rx;
            rx_s_q       <= rx_meta_q;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_txd) begin
                rdata = {24'b0, tx_byte_q};
            end else if (sel_rxd) begin
                rdata = {24'b0, rx_byte_q};
            end else if (sel_con) begin
                rdata = {25'b0, frame_err_q, rx_overrun_q, tx_busy, rx_valid_q,
                         tx_done_q, rx_irq_en_q, tx_irq_en_q};
            end
        end
    end

    assign uart_tx = tx_line_q;
    assign irqout  = (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_valid_q);

endmodule
